// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM pipeline stage and the data-memory responder.
interface data_mem_responder_if;
    localparam int unsigned DW = 32;

    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWrite;
    logic [DW-1:0] ReqAddress;
    logic [DW-1:0] ReqWriteData;
    logic          RespValid;
    logic          RespReady;
    logic [DW-1:0] RespReadData;
    logic          RespError;
    logic          Busy;

    modport master (
        output ReqValid, ReqWrite, ReqAddress, ReqWriteData, RespReady,
        input  ReqReady, RespValid, RespReadData, RespError, Busy
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddress, ReqWriteData, RespReady,
        output ReqReady, RespValid, RespReadData, RespError, Busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder with fixed access latency.
// Stores commit and loads sample memory on the edge that enters RESP.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 ClockInput,
    input  logic                 ResetInput,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam int unsigned CW     = 4;
    localparam bit          SINGLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_write_q, req_write_d;
    logic [DW-1:0]   req_addr_q, req_addr_d;
    logic [DW-1:0]   req_wdata_q, req_wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic            resp_error_q, resp_error_d;
    logic            busy_q, busy_d;

    logic [DW-1:0]   mem [DEPTH_WORDS];

    logic            accept_c;
    logic            cur_write_c;
    logic [DW-1:0]   cur_addr_c;
    logic [DW-1:0]   cur_wdata_c;
    logic            err_c;
    logic [AW-1:0]   idx_c;
    logic [DW-1:0]   mem_rdata_c;
    logic            mem_we_c;

    assign accept_c = bus.ReqValid && req_ready_q;

    // With LATENCY=1 the commit edge is the acceptance edge, so use the live request there.
    assign cur_write_c = (state_q == ST_IDLE) ? bus.ReqWrite     : req_write_q;
    assign cur_addr_c  = (state_q == ST_IDLE) ? bus.ReqAddress   : req_addr_q;
    assign cur_wdata_c = (state_q == ST_IDLE) ? bus.ReqWriteData : req_wdata_q;

    assign err_c = (cur_addr_c[1:0] != 2'b00) ||
                   ({2'b00, cur_addr_c[DW-1:2]} >= DW'(DEPTH_WORDS));
    assign idx_c       = cur_addr_c[AW+1:2];
    assign mem_rdata_c = mem[idx_c];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        mem_we_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    req_write_d = bus.ReqWrite;
                    req_addr_d  = bus.ReqAddress;
                    req_wdata_d = bus.ReqWriteData;
                    cnt_d       = CW'(LATENCY - 1);
                    state_d     = SINGLE ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.RespReady) begin
                    state_d      = ST_IDLE;
                    resp_rdata_d = '0;
                    resp_error_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Commit edge: the edge that moves into RESP.
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            cnt_d        = '0;
            resp_error_d = err_c;
            resp_rdata_d = (!cur_write_c && !err_c) ? mem_rdata_c : '0;
            mem_we_c     = cur_write_c && !err_c;
        end

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge ClockInput or negedge ResetInput) begin
        if (!ResetInput) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            busy_q       <= busy_d;
        end
    end

    // Storage survives reset; only committed stores touch it.
    always_ff @(posedge ClockInput) begin
        if (mem_we_c) begin
            mem[idx_c] <= cur_wdata_c;
        end
    end

    assign bus.ReqReady     = req_ready_q;
    assign bus.RespValid    = resp_valid_q;
    assign bus.RespReadData = resp_rdata_q;
    assign bus.RespError    = resp_error_q;
    assign bus.Busy         = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 2, 4 and 1.
module tb_data_mem_responder;
    logic clk;
    logic rst1_n, rst2_n, rst4_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] ref_mem [0:255];

    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();
    data_mem_responder_if bus4 ();

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .ClockInput(clk), .ResetInput(rst1_n), .bus(bus1));
    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
        .ClockInput(clk), .ResetInput(rst2_n), .bus(bus2));
    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
        .ClockInput(clk), .ResetInput(rst4_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int sel, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        case (sel)
            1: begin bus1.ReqValid = v; bus1.ReqWrite = w; bus1.ReqAddress = a; bus1.ReqWriteData = d; end
            2: begin bus2.ReqValid = v; bus2.ReqWrite = w; bus2.ReqAddress = a; bus2.ReqWriteData = d; end
            default: begin bus4.ReqValid = v; bus4.ReqWrite = w; bus4.ReqAddress = a; bus4.ReqWriteData = d; end
        endcase
    endtask

    task automatic set_rr(input int sel, input logic v);
        case (sel)
            1: bus1.RespReady = v;
            2: bus2.RespReady = v;
            default: bus4.RespReady = v;
        endcase
    endtask

    task automatic sample(input int sel, output logic rdy, output logic vl,
                          output logic [31:0] rd, output logic er, output logic bz);
        case (sel)
            1: begin rdy = bus1.ReqReady; vl = bus1.RespValid; rd = bus1.RespReadData; er = bus1.RespError; bz = bus1.Busy; end
            2: begin rdy = bus2.ReqReady; vl = bus2.RespValid; rd = bus2.RespReadData; er = bus2.RespError; bz = bus2.Busy; end
            default: begin rdy = bus4.ReqReady; vl = bus4.RespValid; rd = bus4.RespReadData; er = bus4.RespError; bz = bus4.Busy; end
        endcase
    endtask

    // One full transaction from an idle negedge; edges counts the acceptance edge as 1, -1 on timeout.
    task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int edges);
        logic rdy, vl, bz;
        drive(sel, 1'b1, w, a, d);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        drive(sel, 1'b0, ~w, ~a, ~d);
        sample(sel, rdy, vl, rd, er, bz);
        while (!vl && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            sample(sel, rdy, vl, rd, er, bz);
        end
        if (!vl) edges = -1;
        set_rr(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rr(sel, 1'b0);
    endtask

    task automatic test_reset();
        logic rdy, vl, er, bz;
        logic [31:0] rd;
        @(negedge clk);
        sample(2, rdy, vl, rd, er, bz);
        n_checks++;
        if ({rdy, vl, er, bz, rd} !== {4'b0000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vl=%b er=%b bz=%b rd=%h expected all 0", rdy, vl, er, bz, rd);
        end
        rst1_n = 1'b1; rst2_n = 1'b1; rst4_n = 1'b1;
        #1;
        sample(2, rdy, vl, rd, er, bz);
        n_checks++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b expected 0", rdy);
        end
        @(posedge clk);
        @(negedge clk);
        sample(2, rdy, vl, rd, er, bz);
        n_checks++;
        if ({rdy, bz} !== 2'b10) begin
            n_fail++;
            $display("FAIL ready_after_edge: got rdy=%b bz=%b expected 1 0", rdy, bz);
        end
        sample(4, rdy, vl, rd, er, bz);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge_l4: got %b expected 1", rdy);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic er;
        int edges;
        txn(2, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, edges);
        n_checks++;
        if ({edges, er, rd} !== {32'd2, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL store_resp: got edges=%0d er=%b rd=%h expected 2 0 0", edges, er, rd);
        end
        txn(2, 1'b0, 32'h10, 32'h0, rd, er, edges);
        n_checks++;
        if ({edges, er, rd} !== {32'd2, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL load_resp: got edges=%0d er=%b rd=%h expected 2 0 deadbeef", edges, er, rd);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic er;
        int edges;
        txn(2, 1'b1, 32'h13, 32'h1, rd, er, edges);
        n_checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL misaligned_store: got er=%b rd=%h expected 1 0", er, rd);
        end
        txn(2, 1'b0, 32'h10, 32'h0, rd, er, edges);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL misaligned_no_write: got er=%b rd=%h expected 0 deadbeef", er, rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic er;
        int edges;
        txn(2, 1'b0, 32'h400, 32'h0, rd, er, edges);
        n_checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL oor_load: got er=%b rd=%h expected 1 0", er, rd);
        end
        txn(2, 1'b1, 32'h3FC, 32'hA5A5_0001, rd, er, edges);
        txn(2, 1'b0, 32'h3FC, 32'h0, rd, er, edges);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'hA5A5_0001}) begin
            n_fail++;
            $display("FAIL last_word_load: got er=%b rd=%h expected 0 a5a50001", er, rd);
        end
        // 0x400 aliases word 0 in the index bits; an erroring store must not land there.
        txn(2, 1'b1, 32'h0, 32'h1111_1111, rd, er, edges);
        txn(2, 1'b1, 32'h400, 32'h0000_0BAD, rd, er, edges);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_store_err: got %b expected 1", er);
        end
        txn(2, 1'b0, 32'h0, 32'h0, rd, er, edges);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h1111_1111}) begin
            n_fail++;
            $display("FAIL oor_store_no_write: got er=%b rd=%h expected 0 11111111", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic rdy, vl, er, bz;
        int edges;
        txn(2, 1'b1, 32'h40, 32'hCAFE_F00D, rd, er, edges);
        txn(2, 1'b1, 32'h44, 32'h4444_4444, rd, er, edges);
        drive(2, 1'b1, 1'b0, 32'h40, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 32'h44, 32'h0BAD_0BAD);
        sample(2, rdy, vl, rd, er, bz);
        n_checks++;
        if ({bz, rdy, vl} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_wait: got bz=%b rdy=%b vl=%b expected 1 0 0", bz, rdy, vl);
        end
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sample(2, rdy, vl, rd, er, bz);
            n_checks++;
            if ({vl, rdy, er, rd} !== {3'b100, 32'hCAFE_F00D}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vl=%b rdy=%b er=%b rd=%h expected 1 0 0 cafef00d", c, vl, rdy, er, rd);
            end
            if (c < 5) @(posedge clk);
        end
        set_rr(2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        sample(2, rdy, vl, rd, er, bz);
        n_checks++;
        if ({vl, bz, rdy} !== 3'b001) begin
            n_fail++;
            $display("FAIL bp_handshake: got vl=%b bz=%b rdy=%b expected 0 0 1", vl, bz, rdy);
        end
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rr(2, 1'b0);
        txn(2, 1'b0, 32'h44, 32'h0, rd, er, edges);
        n_checks++;
        if (rd !== 32'h4444_4444) begin
            n_fail++;
            $display("FAIL bp_no_accept: got %h expected 44444444", rd);
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd;
        logic rdy, vl, er, bz;
        int edges;
        txn(4, 1'b1, 32'h20, 32'h1234_5678, rd, er, edges);
        n_checks++;
        if (edges !== 4) begin
            n_fail++;
            $display("FAIL l4_latency: got %0d expected 4", edges);
        end
        drive(4, 1'b1, 1'b1, 32'h20, 32'h5);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sample(4, rdy, vl, rd, er, bz);
        n_checks++;
        if ({bz, vl} !== 2'b10) begin
            n_fail++;
            $display("FAIL l4_in_wait: got bz=%b vl=%b expected 1 0", bz, vl);
        end
        rst4_n = 1'b0;
        #1;
        sample(4, rdy, vl, rd, er, bz);
        n_checks++;
        if ({rdy, vl, er, bz, rd} !== {4'b0000, 32'h0}) begin
            n_fail++;
            $display("FAIL l4_reset_outputs: got rdy=%b vl=%b er=%b bz=%b rd=%h expected all 0", rdy, vl, er, bz, rd);
        end
        @(negedge clk);
        @(negedge clk);
        rst4_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        txn(4, 1'b0, 32'h20, 32'h0, rd, er, edges);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL l4_aborted_store: got er=%b rd=%h expected 0 12345678", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, a, d, exp;
        logic rdy, vl, er, bz, w;
        int k;
        set_rr(1, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            k = i / 2;
            w = (i % 2 == 0);
            a = 32'h80 + 32'(k * 4);
            d = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
            sample(1, rdy, vl, rd, er, bz);
            n_checks++;
            if (rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: got %b expected 1", i, rdy);
            end
            drive(1, 1'b1, w, a, w ? d : 32'hFFFF_FFFF);
            exp = w ? 32'h0 : ref_mem[k];
            if (w) ref_mem[k] = d;
            @(posedge clk);
            @(negedge clk);
            sample(1, rdy, vl, rd, er, bz);
            n_checks++;
            if ({vl, rdy, er, rd} !== {3'b100, exp}) begin
                n_fail++;
                $display("FAIL b2b_resp_%0d: got vl=%b rdy=%b er=%b rd=%h expected 1 0 0 %h", i, vl, rdy, er, rd, exp);
            end
            @(posedge clk);
            @(negedge clk);
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(1, rdy, vl, rd, er, bz);
        n_checks++;
        if ({rdy, vl} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_end: got rdy=%b vl=%b expected 1 0", rdy, vl);
        end
        set_rr(1, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst1_n = 1'b0; rst2_n = 1'b0; rst4_n = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rr(1, 1'b0); set_rr(2, 1'b0); set_rr(4, 1'b0);
        @(negedge clk);
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_reset_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
